led_pattern_gen: RTL and testbench

//  Parametrised LED activity generator; successor to the free-running LED divider counter.

---
 rtl/led_pkg.sv | 32 +++
 rtl/led_prescaler.sv | 32 +++
 rtl/led_pattern_gen.sv | 188 ++++++++++++++++++
 tb/tb_led_pattern_gen.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared definitions for the LED pattern generator.
//   mode_e      : pattern engine mode, encoded as on the 2-bit mode input
//   scan_dir_e  : direction of the bouncing scan dot
//   ramp_e      : direction of the breathe duty ramp
//   gray_encode : binary to reflected Gray code, up to MAX_W bits
package led_pkg;

  localparam int MAX_W = 32;

  typedef enum logic [1:0] {
    MODE_BIN     = 2'd0,
    MODE_GRAY    = 2'd1,
    MODE_SCAN    = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_e;

  typedef enum logic {
    SCAN_LEFT  = 1'b0,
    SCAN_RIGHT = 1'b1
  } scan_dir_e;

  typedef enum logic {
    RAMP_UP   = 1'b0,
    RAMP_DOWN = 1'b1
  } ramp_e;

  // Callers zero-extend narrower values to MAX_W and truncate the result.
  function automatic logic [MAX_W-1:0] gray_encode(input logic [MAX_W-1:0] value);
    return value ^ (value >> 1);
  endfunction

endpackage

// File: rtl/led_prescaler.sv
// Free-running prescaler producing a one-cycle strobe every 2**WIDTH enabled cycles.
//   clk   in  system clock
//   rst   in  synchronous reset, active-high
//   en    in  count enable; while low the count holds and tick stays low
//   clear in  synchronous restart of the count (same effect as rst)
//   tick  out registered strobe, high the cycle after the count wrapped
module led_prescaler #(
  parameter int WIDTH = 21
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clear,
  output logic tick
);

  logic [WIDTH-1:0] count;

  // tick is raised on the edge where the all-ones count rolls over to zero.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
      tick  <= 1'b0;
    end else if (en) begin
      count <= count + 1'b1;
      tick  <= &count;
    end else begin
      tick  <= 1'b0;
    end
  end

endmodule

// File: rtl/led_pattern_gen.sv
// LED activity generator: a prescaled tick advances one of four pattern engines
// (binary count, Gray count, bouncing scan, PWM breathe) and the selected pattern
// drives the LEDs active-low.
//   clk      in  system clock
//   rst      in  synchronous reset, active-high
//   en       in  prescaler enable (PWM carrier runs regardless)
//   mode     in  0 BIN, 1 GRAY, 2 SCAN, 3 BREATHE
//   dir      in  BIN/GRAY count direction, 0 up, 1 down
//   load     in  load load_val into the binary counter
//   load_val in  value for load
//   led      out LED drive, active-low
//   tick     out one-cycle strobe per prescaler wrap
//   wrap     out one-cycle strobe at a pattern cycle boundary, aligned with led
module led_pattern_gen
  import led_pkg::*;
#(
  parameter int LED_W      = 8,
  parameter int PRESCALE_W = 21,
  parameter int PWM_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             dir,
  input  logic             load,
  input  logic [LED_W-1:0] load_val,
  output logic [LED_W-1:0] led,
  output logic             tick,
  output logic             wrap
);

  localparam int POS_W = (LED_W > 2) ? $clog2(LED_W) : 1;
  localparam logic [POS_W-1:0] POS_MAX  = POS_W'(LED_W - 1);
  localparam logic [PWM_W-1:0] DUTY_MAX = '1;

  mode_e            mode_q;
  logic             mode_change;
  logic             step;

  logic [LED_W-1:0] bin;
  logic [POS_W-1:0] pos;
  logic [POS_W-1:0] pos_next;
  scan_dir_e        scan_dir;
  scan_dir_e        scan_dir_next;
  logic [PWM_W-1:0] duty;
  logic [PWM_W-1:0] duty_next;
  ramp_e            ramp;
  ramp_e            ramp_next;
  logic [PWM_W-1:0] pwm_cnt;

  logic [LED_W-1:0] pattern;
  logic             wrap_cond;
  logic             wrap_evt;

  // A mode change restarts the prescaler and swallows any pending tick; a load
  // also takes the place of a tick step.
  assign mode_change = (mode_e'(mode) != mode_q);
  assign step        = tick & ~load & ~mode_change;

  led_prescaler #(
    .WIDTH(PRESCALE_W)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clear(mode_change),
    .tick (tick)
  );

  // mode_q captures mode every cycle, including during reset, so reset itself
  // never looks like a mode change.
  always_ff @(posedge clk) begin
    mode_q <= mode_e'(mode);
  end

  // Binary counter shared by BIN and GRAY; kept across other modes.
  always_ff @(posedge clk) begin
    if (rst) begin
      bin <= '0;
    end else if (load) begin
      bin <= load_val;
    end else if (step && (mode_q == MODE_BIN || mode_q == MODE_GRAY)) begin
      bin <= dir ? bin - 1'b1 : bin + 1'b1;
    end
  end

  // Next scan position: bounce at both ends so each end is lit for one tick.
  always_comb begin
    pos_next      = pos;
    scan_dir_next = scan_dir;
    if (scan_dir == SCAN_LEFT) begin
      if (pos == POS_MAX) begin
        pos_next      = POS_MAX - 1'b1;
        scan_dir_next = SCAN_RIGHT;
      end else begin
        pos_next = pos + 1'b1;
      end
    end else begin
      if (pos == '0) begin
        pos_next      = POS_W'(1);
        scan_dir_next = SCAN_LEFT;
      end else begin
        pos_next = pos - 1'b1;
      end
    end
  end

  // Scan state.
  always_ff @(posedge clk) begin
    if (rst || mode_change) begin
      pos      <= '0;
      scan_dir <= SCAN_LEFT;
    end else if (step && mode_q == MODE_SCAN) begin
      pos      <= pos_next;
      scan_dir <= scan_dir_next;
    end
  end

  // Next duty: at either endpoint the duty holds for one tick while the ramp turns.
  always_comb begin
    duty_next = duty;
    ramp_next = ramp;
    if (ramp == RAMP_UP) begin
      if (duty == DUTY_MAX) ramp_next = RAMP_DOWN;
      else                  duty_next = duty + 1'b1;
    end else begin
      if (duty == '0) ramp_next = RAMP_UP;
      else            duty_next = duty - 1'b1;
    end
  end

  // Breathe state.
  always_ff @(posedge clk) begin
    if (rst || mode_change) begin
      duty <= '0;
      ramp <= RAMP_UP;
    end else if (step && mode_q == MODE_BREATHE) begin
      duty <= duty_next;
      ramp <= ramp_next;
    end
  end

  // PWM carrier keeps running while the prescaler is disabled.
  always_ff @(posedge clk) begin
    if (rst) pwm_cnt <= '0;
    else     pwm_cnt <= pwm_cnt + 1'b1;
  end

  // Pattern selection and the cycle-boundary condition for the active mode.
  always_comb begin
    pattern   = '0;
    wrap_cond = 1'b0;
    case (mode_q)
      MODE_BIN: begin
        pattern   = bin;
        wrap_cond = dir ? (bin == '0) : (&bin);
      end
      MODE_GRAY: begin
        pattern   = LED_W'(gray_encode(MAX_W'(bin)));
        wrap_cond = dir ? (bin == '0) : (&bin);
      end
      MODE_SCAN: begin
        pattern   = LED_W'(1) << pos;
        wrap_cond = (pos_next == '0) && (pos != '0);
      end
      MODE_BREATHE: begin
        pattern   = (pwm_cnt < duty) ? '1 : '0;
        wrap_cond = (duty_next == '0) && (duty != '0);
      end
    endcase
  end

  // wrap_evt is captured on the step edge and delayed one cycle so wrap rises
  // together with the led value of the step that caused it.
  always_ff @(posedge clk) begin
    if (rst) begin
      led      <= '1;
      wrap     <= 1'b0;
      wrap_evt <= 1'b0;
    end else begin
      led      <= ~pattern;
      wrap     <= wrap_evt;
      wrap_evt <= step & wrap_cond;
    end
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Self-checking bench for led_pattern_gen with a small prescaler.
module tb_led_pattern_gen;

  localparam int LED_W          = 8;
  localparam int PRESCALE_W     = 2;
  localparam int PWM_W          = 2;
  localparam int PRESC_PERIOD   = 2 ** PRESCALE_W;
  localparam int PWM_PERIOD     = 2 ** PWM_W;
  localparam int DUTY_TOP       = PWM_PERIOD - 1;
  localparam int SCAN_PERIOD    = 2 * (LED_W - 1);
  localparam int BREATHE_PERIOD = 2 * PWM_PERIOD;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [1:0]       mode;
  logic             dir;
  logic             load;
  logic [LED_W-1:0] load_val;
  logic [LED_W-1:0] led;
  logic             tick;
  logic             wrap;

  int checks = 0;
  int errors = 0;

  led_pattern_gen #(
    .LED_W(LED_W),
    .PRESCALE_W(PRESCALE_W),
    .PWM_W(PWM_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .mode    (mode),
    .dir     (dir),
    .load    (load),
    .load_val(load_val),
    .led     (led),
    .tick    (tick),
    .wrap    (wrap)
  );

  always #5 clk = ~clk;

  // Reference state: positions in the scan and breathe cycles are phases of a
  // periodic sequence rather than position/direction registers.
  bit               m_valid = 1'b0;
  int               m_presc, m_bin, m_scan_ph, m_br_ph, m_pwm, m_mode_q, m_nb;
  bit               m_tick, m_wrap_evt, m_wrap, m_step, m_evt;
  logic [LED_W-1:0] m_led, m_pat, m_b;

  function automatic int scan_pos(input int ph);
    return (ph <= LED_W - 1) ? ph : SCAN_PERIOD - ph;
  endfunction

  function automatic int breathe_duty(input int ph);
    return (ph <= DUTY_TOP) ? ph : BREATHE_PERIOD - 1 - ph;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit e, input logic [1:0] m,
                               input bit d, input bit l, input logic [LED_W-1:0] lv);
    rst      = r;
    en       = e;
    mode     = m;
    dir      = d;
    load     = l;
    load_val = lv;
  endtask

  task automatic waitTick(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tick !== 1'b1 && n < 40);
    checkOutput("tick_seen", {31'd0, tick}, 32'd1);
  endtask

  // Reference model, advanced on every rising edge from the inputs and its own
  // previous state; the led it produces reflects the state before the edge.
  always @(posedge clk) begin
    if (rst) begin
      m_valid    = 1'b1;
      m_presc    = 0;
      m_tick     = 1'b0;
      m_bin      = 0;
      m_scan_ph  = 0;
      m_br_ph    = 0;
      m_pwm      = 0;
      m_mode_q   = int'(mode);
      m_led      = '1;
      m_wrap     = 1'b0;
      m_wrap_evt = 1'b0;
    end else if (m_valid) begin
      m_b = m_bin[LED_W-1:0];
      case (m_mode_q)
        0:       m_pat = m_b;
        1:       m_pat = m_b ^ (m_b >> 1);
        2:       m_pat = LED_W'(1) << scan_pos(m_scan_ph);
        default: m_pat = (m_pwm < breathe_duty(m_br_ph)) ? '1 : '0;
      endcase
      m_led  = ~m_pat;
      m_wrap = m_wrap_evt;
      m_step = m_tick && !load && (int'(mode) == m_mode_q);
      m_evt  = 1'b0;
      if (m_step) begin
        case (m_mode_q)
          0, 1: begin
            m_nb  = dir ? (m_bin + 255) % 256 : (m_bin + 1) % 256;
            m_evt = dir ? (m_nb == 255) : (m_nb == 0);
            m_bin = m_nb;
          end
          2: begin
            m_scan_ph = (m_scan_ph + 1) % SCAN_PERIOD;
            m_evt     = (m_scan_ph == 0);
          end
          default: begin
            m_br_ph = (m_br_ph + 1) % BREATHE_PERIOD;
            m_evt   = (m_br_ph == BREATHE_PERIOD - 1);
          end
        endcase
      end
      if (load) m_bin = int'(load_val);
      m_wrap_evt = m_evt;
      if (int'(mode) != m_mode_q) begin
        m_presc   = 0;
        m_tick    = 1'b0;
        m_scan_ph = 0;
        m_br_ph   = 0;
        m_mode_q  = int'(mode);
      end else if (en) begin
        m_tick  = (m_presc == PRESC_PERIOD - 1);
        m_presc = (m_presc + 1) % PRESC_PERIOD;
      end else begin
        m_tick = 1'b0;
      end
      m_pwm = (m_pwm + 1) % PWM_PERIOD;
    end
  end

  // Every-cycle comparison against the reference model.
  always @(negedge clk) begin
    if (m_valid) begin
      checkOutput("model_led", {24'd0, led}, {24'd0, m_led});
      checkOutput("model_tick", {31'd0, tick}, {31'd0, m_tick});
      checkOutput("model_wrap", {31'd0, wrap}, {31'd0, m_wrap});
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n, on, bad;
    logic [LED_W-1:0] exp_led;

    // Reset and first BIN step.
    applyStimulus(1, 1, 2'd0, 0, 0, '0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkOutput("reset_led", {24'd0, led}, 32'hFF);
    checkOutput("reset_tick", {31'd0, tick}, 32'd0);
    checkOutput("reset_wrap", {31'd0, wrap}, 32'd0);
    waitTick(n);
    checkOutput("first_tick_latency", n, 32'd4);
    repeat (2) @(negedge clk);
    checkOutput("bin_first_step", {24'd0, led}, 32'hFE);
    // Two of the four cycles of the period were spent waiting for the led.
    waitTick(n);
    checkOutput("tick_period", n, 32'd2);

    // Load on a tick cycle: load wins, then FF and the wrap to 00.
    applyStimulus(0, 1, 2'd0, 0, 1, 8'hFE);
    @(negedge clk);
    load = 1'b0;
    waitTick(n);
    repeat (2) @(negedge clk);
    checkOutput("bin_ff_led", {24'd0, led}, 32'h00);
    checkOutput("bin_ff_wrap", {31'd0, wrap}, 32'd0);
    waitTick(n);
    repeat (2) @(negedge clk);
    checkOutput("bin_00_led", {24'd0, led}, 32'hFF);
    checkOutput("bin_00_wrap", {31'd0, wrap}, 32'd1);
    @(negedge clk);
    checkOutput("wrap_one_cycle", {31'd0, wrap}, 32'd0);

    // GRAY counting down from 5.
    applyStimulus(0, 1, 2'd1, 1, 1, 8'h05);
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    checkOutput("gray_5", {24'd0, led}, 32'hF8);
    waitTick(n);
    repeat (2) @(negedge clk);
    checkOutput("gray_4", {24'd0, led}, 32'hF9);
    waitTick(n);
    repeat (2) @(negedge clk);
    checkOutput("gray_3", {24'd0, led}, 32'hFD);

    // SCAN over 16 ticks.
    applyStimulus(0, 1, 2'd2, 0, 0, '0);
    for (int k = 1; k <= 16; k++) begin
      waitTick(n);
      repeat (2) @(negedge clk);
      exp_led = ~(LED_W'(1) << scan_pos(k % SCAN_PERIOD));
      checkOutput("scan_led", {24'd0, led}, {24'd0, exp_led});
      checkOutput("scan_wrap", {31'd0, wrap}, {31'd0, (k % SCAN_PERIOD) == 0});
      checkOutput("scan_onehot", $countones(~led), 32'd1);
    end

    // BREATHE: measure the on-time over each 4-cycle tick window.
    applyStimulus(0, 1, 2'd3, 0, 0, '0);
    waitTick(n);
    @(negedge clk);
    bad = 0;
    for (int k = 1; k <= 9; k++) begin
      on = 0;
      for (int s = 0; s < PRESC_PERIOD; s++) begin
        @(negedge clk);
        if (s == 0)
          checkOutput("breathe_wrap", {31'd0, wrap}, {31'd0, (k % BREATHE_PERIOD) == 7});
        if (led == 8'h00) on++;
        else if (led != 8'hFF) bad++;
      end
      checkOutput("breathe_duty", on, breathe_duty(k % BREATHE_PERIOD));
    end
    checkOutput("breathe_all_or_none", bad, 32'd0);
    // Disabled: duty frozen at the level of step 10 while PWM keeps toggling.
    en = 1'b0;
    @(negedge clk);
    on = 0;
    bad = 0;
    for (int s = 0; s < 8; s++) begin
      @(negedge clk);
      if (led == 8'h00) on++;
      if (tick) bad++;
    end
    checkOutput("breathe_frozen_on", on, 32'd4);
    checkOutput("breathe_frozen_tick", bad, 32'd0);
    en = 1'b1;

    // Mode change mid-prescale restarts the prescaler.
    applyStimulus(0, 1, 2'd0, 0, 0, '0);
    waitTick(n);
    repeat (2) @(negedge clk);
    mode = 2'd2;
    repeat (2) @(negedge clk);
    checkOutput("modechg_scan_pos0", {24'd0, led}, 32'hFE);
    waitTick(n);
    checkOutput("modechg_restart", n, 32'd3);

    // Reset asserted together with load and a pending tick.
    applyStimulus(1, 1, 2'd2, 0, 1, 8'hAA);
    @(negedge clk);
    checkOutput("rst_wins_led", {24'd0, led}, 32'hFF);
    checkOutput("rst_wins_tick", {31'd0, tick}, 32'd0);
    checkOutput("rst_wins_wrap", {31'd0, wrap}, 32'd0);
    applyStimulus(0, 1, 2'd0, 0, 0, '0);
    repeat (2) @(negedge clk);
    checkOutput("rst_beats_load", {24'd0, led}, 32'hFF);

    // Randomised operation against the model.
    for (int c = 0; c < 4000; c++) begin
      applyStimulus($urandom_range(0, 299) == 0,
                    $urandom_range(0, 9) != 0,
                    ($urandom_range(0, 79) == 0) ? 2'($urandom_range(0, 3)) : mode,
                    ($urandom_range(0, 49) == 0) ? ~dir : dir,
                    $urandom_range(0, 39) == 0,
                    LED_W'($urandom));
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
